// File: rtl/core_pkg.sv
// Shared definitions for the execute-stage M-extension sequencer:
// funct3 op codes, FSM state encoding and a small op-class helper.
package core_pkg;

    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } muldiv_state_e;

    // Divide/remainder ops all have funct3[2] set.
    function automatic logic muldiv_is_div(input logic [2:0] f);
        return f[2];
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath shared by multiply and divide. The 2*XLEN accumulator
// holds {high product, multiplier} for multiply (shifts right) and
// {remainder, dividend/quotient} for divide (shifts left).
module muldiv_core
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_is_div,
    input  logic [XLEN-1:0]   i_lo_init,
    input  logic [XLEN-1:0]   i_opnd_init,
    output logic [2*XLEN-1:0] o_acc_next
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shl;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_acc_step;

    // One shift-add (multiply) or restoring subtract (divide) iteration.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
        w_shl      = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_diff     = w_shl - {1'b0, r_opnd};
        w_acc_step = r_acc;
        if (i_is_div) begin
            if (w_shl >= {1'b0, r_opnd}) begin
                w_acc_step = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end else begin
                w_acc_step = {w_shl[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            end
        end else begin
            if (r_acc[0]) begin
                w_acc_step = {w_sum, r_acc[XLEN-1:1]};
            end else begin
                w_acc_step = {1'b0, r_acc[2*XLEN-1:1]};
            end
        end
    end

    assign o_acc_next = w_acc_step;

    // Accumulator/operand registers: load on op accept, advance on each step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_opnd <= '0;
        end else if (i_load) begin
            r_acc  <= {{XLEN{1'b0}}, i_lo_init};
            r_opnd <= i_opnd_init;
        end else if (i_step) begin
            r_acc  <= w_acc_step;
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage RV32M sequencer: captures operands, runs the iterative core for
// XLEN cycles (or short-cuts divide-by-zero/overflow), stalls the pipe and
// presents a one-cycle done strobe with the sign-corrected result.
module ex_muldiv_ctrl
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     r_state, w_state_next;
    logic [CW-1:0]     r_counter;
    logic [2:0]        r_funct3;
    logic              r_neg_q, r_neg_r, r_busy, r_done;
    logic [XLEN-1:0]   r_result;

    logic              w_a_signed, w_b_signed, w_sa, w_sb;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_lo_init, w_opnd_init;
    logic              w_div_zero, w_ovf, w_special, w_accept;
    logic [XLEN-1:0]   w_special_res, w_final, w_quo, w_rem;
    logic [2*XLEN-1:0] w_acc_next, w_prod;
    logic              w_load, w_step, w_finish;

    // Operand signedness, magnitudes and special-case detection for the op in EX.
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (funct3)
            MULDIV_MUL, MULDIV_MULH: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            MULDIV_MULHSU: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b0;
            end
            MULDIV_DIV, MULDIV_REM: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            default: begin
                w_a_signed = 1'b0;
                w_b_signed = 1'b0;
            end
        endcase
        w_sa = w_a_signed & A[XLEN-1];
        w_sb = w_b_signed & B[XLEN-1];
        if (w_sa) begin
            w_a_mag = -A;
        end else begin
            w_a_mag = A;
        end
        if (w_sb) begin
            w_b_mag = -B;
        end else begin
            w_b_mag = B;
        end
        if (muldiv_is_div(funct3)) begin
            w_lo_init   = w_a_mag;
            w_opnd_init = w_b_mag;
        end else begin
            w_lo_init   = w_b_mag;
            w_opnd_init = w_a_mag;
        end
        w_div_zero = muldiv_is_div(funct3) & (B == {XLEN{1'b0}});
        w_ovf      = muldiv_is_div(funct3) & ~funct3[0] & (A == INT_MIN) & (B == {XLEN{1'b1}});
        w_special  = w_div_zero | w_ovf;
        if (w_div_zero) begin
            w_special_res = funct3[1] ? A : {XLEN{1'b1}};
        end else if (w_ovf) begin
            w_special_res = funct3[1] ? {XLEN{1'b0}} : INT_MIN;
        end else begin
            w_special_res = {XLEN{1'b0}};
        end
    end

    assign w_accept = (r_state == S_IDLE) & start & ~flush;

    // Next-state logic and datapath load/step enables.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_load       = 1'b1;
                    w_state_next = w_special ? S_DONE : S_CALC;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_counter == CNT_LAST) begin
                        w_finish     = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_CALC;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    muldiv_core #(.XLEN(XLEN)) u_core (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_is_div    (muldiv_is_div(r_funct3)),
        .i_lo_init   (w_lo_init),
        .i_opnd_init (w_opnd_init),
        .o_acc_next  (w_acc_next)
    );

    // Sign fix-up and high/low selection on the final iteration's output.
    always_comb begin
        w_prod = r_neg_q ? -w_acc_next : w_acc_next;
        w_quo  = r_neg_q ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
        w_rem  = r_neg_r ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];
        case (r_funct3)
            MULDIV_MUL:                              w_final = w_prod[XLEN-1:0];
            MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
            MULDIV_DIV, MULDIV_DIVU:                 w_final = w_quo;
            MULDIV_REM, MULDIV_REMU:                 w_final = w_rem;
            default:                                 w_final = {XLEN{1'b0}};
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Op capture, iteration counter, result and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_counter <= '0;
            r_funct3  <= 3'b000;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_busy <= (w_state_next == S_CALC);
            r_done <= (w_state_next == S_DONE);
            if (w_accept) begin
                r_counter <= '0;
                r_funct3  <= funct3;
                r_neg_q   <= w_sa ^ w_sb;
                r_neg_r   <= w_sa;
                if (w_special) begin
                    r_result <= w_special_res;
                end
            end else if (w_step) begin
                r_counter <= r_counter + CW'(1);
                if (w_finish) begin
                    r_result <= w_final;
                end
            end
        end
    end

    assign stall  = ~rst & (w_accept | (r_state == S_CALC));
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Scoreboard bench for ex_muldiv_ctrl: the driver pushes expected result and
// done cycle per op; a negedge monitor pops and compares on every done pulse.
module tb_ex_muldiv_ctrl;

    localparam int XLEN = 32;
    localparam int LAT_N = 33;
    localparam int LAT_S = 1;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    ex_muldiv_ctrl #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .A      (A),
        .B      (B),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one op with start held until done; checks stall/busy each cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int lat);
        exp_t e;
        int   t0;
        logic got;
        logic exp_stall;
        logic exp_busy;
        @(posedge clk);
        #1;
        start  = 1'b1;
        funct3 = f;
        A      = a;
        B      = b;
        t0     = cyc;
        e.res  = exp_res;
        e.cyc  = 32'(t0 + lat);
        sb.push_back(e);
        got = 1'b0;
        for (int n = 0; n <= 40 && !got; n++) begin
            @(negedge clk);
            exp_stall = (n < lat);
            exp_busy  = (n >= 1) && (n < lat);
            check("stall", {31'd0, stall}, {31'd0, exp_stall});
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            if (done) got = 1'b1;
        end
        if (!got) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b1;
        funct3 = 3'b000;
        A      = 32'd5;
        B      = 32'd3;
        flush  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;

        // Multiply family
        run_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_N); idle();
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_N); idle();
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LAT_N); idle();
        run_op(3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LAT_N); idle();

        // Divide family
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LAT_N); idle();
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LAT_N); idle();
        run_op(3'b101, 32'd100,      32'd7, 32'd14,       LAT_N); idle();
        run_op(3'b111, 32'd100,      32'd7, 32'd2,        LAT_N); idle();

        // Special cases
        run_op(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, LAT_S); idle();
        run_op(3'b110, 32'd5,        32'd0,        32'd5,        LAT_S); idle();
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_S); idle();
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        LAT_S); idle();

        // Back-to-back with start held through DONE
        run_op(3'b000, 32'd3,   32'd5, 32'd15, LAT_N);
        run_op(3'b101, 32'd100, 32'd7, 32'd14, LAT_N);
        run_op(3'b101, 32'd5,   32'd0, 32'hFFFFFFFF, LAT_S);
        run_op(3'b110, 32'd5,   32'd0, 32'd5, LAT_S);
        idle();

        // Flush in CALC cycle 10: no done, stall/busy drop next cycle
        @(posedge clk);
        #1;
        start  = 1'b1;
        funct3 = 3'b000;
        A      = 32'h00012345;
        B      = 32'h00000777;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("flush_stall_cur", {31'd0, stall}, 32'd1);
        check("flush_busy_cur", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy_next", {31'd0, busy}, 32'd0);
        check("flush_stall_next", {31'd0, stall}, 32'd0);
        repeat (40) @(negedge clk);

        // Flush and start together in IDLE: flush wins
        @(posedge clk);
        #1;
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'b100;
        A      = 32'd10;
        B      = 32'd3;
        @(negedge clk);
        check("flush_start_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_start_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-CALC (previous result is 5, non-zero)
        @(posedge clk);
        #1;
        start  = 1'b1;
        funct3 = 3'b101;
        A      = 32'd1000;
        B      = 32'd3;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_stall", {31'd0, stall}, 32'd0);
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Recovery after reset
        run_op(3'b101, 32'd1000, 32'd3, 32'd333, LAT_N); idle();

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
